// File: rtl/matmul_loop_sequencer.sv
// matmul_loop_sequencer: walks (i,j,k) for D=AxB, issues address triples and read-latency-aligned MAC/D-write strobes
module matmul_loop_sequencer #(
  parameter int DIM_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] ci,
  input  logic [DIM_W-1:0] cj,
  input  logic [DIM_W-1:0] ck,
  input  logic             hold,
  output logic [DIM_W-1:0] si,
  output logic [DIM_W-1:0] sj,
  output logic [DIM_W-1:0] sk,
  output logic             issue_vld,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             d_we,
  output logic [DIM_W-1:0] wr_i,
  output logic [DIM_W-1:0] wr_j,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [DIM_W-1:0] ONE = 1;
  state_t           state_q;
  logic [DIM_W-1:0] ci_q, cj_q, ck_q;
  logic [DIM_W-1:0] si_q, sj_q, sk_q, si_d, sj_d, sk_d;
  logic [RD_LAT-1:0] vld_q, first_q, last_q;
  logic [DIM_W-1:0] pi_q [RD_LAT];
  logic [DIM_W-1:0] pj_q [RD_LAT];
  logic             d_we_q;
  logic [DIM_W-1:0] wr_i_q, wr_j_q;
  logic             issue, k_end, j_end, i_end, last_trip, wr_now;
  always_comb begin
    issue     = state_q == RUN && !hold;
    k_end     = sk_q == ck_q - ONE;
    j_end     = sj_q == cj_q - ONE;
    i_end     = si_q == ci_q - ONE;
    last_trip = k_end && j_end && i_end;
    sk_d      = k_end ? '0 : sk_q + ONE;
    sj_d      = k_end ? (j_end ? '0 : sj_q + ONE) : sj_q;
    si_d      = (k_end && j_end) ? si_q + ONE : si_q;
    wr_now    = vld_q[RD_LAT-1] & last_q[RD_LAT-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ci_q    <= '0;
      cj_q    <= '0;
      ck_q    <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      sk_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          ci_q    <= ci;
          cj_q    <= cj;
          ck_q    <= ck;
          state_q <= (|ci && |cj && |ck) ? RUN : DONE;
        end
        RUN: if (issue) begin
          if (last_trip) state_q <= DRAIN;
          else begin
            si_q <= si_d;
            sj_q <= sj_d;
            sk_q <= sk_d;
          end
        end
        DRAIN: if (~|vld_q) state_q <= DONE;
        default: begin
          state_q <= IDLE;
          si_q    <= '0;
          sj_q    <= '0;
          sk_q    <= '0;
        end
      endcase
    end
  end
  // first/last are qualified by issue so a stalled slot never carries a stray clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        pi_q[s] <= '0;
        pj_q[s] <= '0;
      end
      d_we_q <= 1'b0;
      wr_i_q <= '0;
      wr_j_q <= '0;
    end else begin
      for (int s = RD_LAT - 1; s > 0; s--) begin
        vld_q[s]   <= vld_q[s-1];
        first_q[s] <= first_q[s-1];
        last_q[s]  <= last_q[s-1];
        pi_q[s]    <= pi_q[s-1];
        pj_q[s]    <= pj_q[s-1];
      end
      vld_q[0]   <= issue;
      first_q[0] <= issue && sk_q == '0;
      last_q[0]  <= issue && k_end;
      pi_q[0]    <= si_q;
      pj_q[0]    <= sj_q;
      d_we_q     <= wr_now;
      if (wr_now) begin
        wr_i_q <= pi_q[RD_LAT-1];
        wr_j_q <= pj_q[RD_LAT-1];
      end
    end
  end
  assign si        = si_q;
  assign sj        = sj_q;
  assign sk        = sk_q;
  assign issue_vld = issue;
  assign mac_en    = vld_q[RD_LAT-1];
  assign mac_clr   = first_q[RD_LAT-1];
  assign d_we      = d_we_q;
  assign wr_i      = wr_i_q;
  assign wr_j      = wr_j_q;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
endmodule

// File: tb/tb_matmul_loop_sequencer.sv
// tb_matmul_loop_sequencer: randomized and directed checks against a schedule-level reference model
module tb_matmul_loop_sequencer;
  localparam int W = 8;
  localparam int L = 1;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hold = 1'b0;
  logic [W-1:0] ci = '0, cj = '0, ck = '0;
  logic [W-1:0] si, sj, sk, wr_i, wr_j;
  logic issue_vld, mac_en, mac_clr, d_we, busy, done;
  int nchk = 0, nerr = 0;
  int hq [1024];
  logic [5:0]  es [1024];
  logic [23:0] ei [1024];
  logic [15:0] ew [1024];
  matmul_loop_sequencer #(.DIM_W(W), .RD_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ci(ci), .cj(cj), .ck(ck), .hold(hold),
    .si(si), .sj(sj), .sk(sk), .issue_vld(issue_vld), .mac_en(mac_en), .mac_clr(mac_clr),
    .d_we(d_we), .wr_i(wr_i), .wr_j(wr_j), .busy(busy), .done(done));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @%0t got %h exp %h", tag, $time, got, exp);
    end
  endtask
  // expected per-cycle outputs from the issue schedule: the n-th issued triple is the
  // n-th element of the i/j/k nest; stalls repeat the pending triple without issuing
  task automatic model(input int a, input int b, input int k, output int dc);
    int n, c, i, j, kk;
    for (int x = 0; x < 1024; x++) begin
      es[x] = '0;
      ei[x] = '0;
      ew[x] = '0;
    end
    if (a == 0 || b == 0 || k == 0) begin
      es[1] = 6'b000011;
      dc = 1;
      return;
    end
    n = 0;
    c = 1;
    while (n < a * b * k) begin
      i  = n / (b * k);
      j  = (n / k) % b;
      kk = n % k;
      ei[c] = {8'(i), 8'(j), 8'(kk)};
      if (hq[c] == 0) begin
        es[c][5] = 1'b1;
        es[c+L][4] = 1'b1;
        if (kk == 0) es[c+L][3] = 1'b1;
        if (kk == k - 1) begin
          es[c+L+1][2] = 1'b1;
          ew[c+L+1] = {8'(i), 8'(j)};
        end
        n++;
      end
      c++;
    end
    dc = c - 1 + L + 2;
    for (int x = c; x <= dc; x++) ei[x] = {8'(a - 1), 8'(b - 1), 8'(k - 1)};
    for (int x = 1; x <= dc; x++) es[x][1] = 1'b1;
    es[dc][0] = 1'b1;
  endtask
  // hmode: 0 no stall, 1 random stalls, 2 stall cycles 2-3; garb re-pulses start with junk dims
  task automatic run(input int a, input int b, input int k, input int hmode, input bit garb);
    int dc;
    for (int x = 0; x < 1024; x++)
      hq[x] = (hmode == 1) ? int'($urandom_range(0, 3) == 0) : (hmode == 2 && (x == 2 || x == 3)) ? 1 : 0;
    model(a, b, k, dc);
    @(negedge clk);
    start = 1'b1;
    ci = W'(a);
    cj = W'(b);
    ck = W'(k);
    hold = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    ci = W'($urandom);
    cj = W'($urandom);
    ck = W'($urandom);
    for (int c = 1; c <= dc + 1; c++) begin
      hold = hq[c][0];
      start = garb && c <= dc ? 1'($urandom_range(0, 1)) : 1'b0;
      if (garb) begin
        ci = W'($urandom_range(1, 5));
        cj = W'($urandom_range(1, 5));
        ck = W'($urandom_range(1, 5));
      end
      @(negedge clk);
      check($sformatf("strb c%0d", c), {26'd0, issue_vld, mac_en, mac_clr, d_we, busy, done}, {26'd0, es[c]});
      check($sformatf("idx c%0d", c), {8'd0, si, sj, sk}, {8'd0, ei[c]});
      if (es[c][2]) check($sformatf("wr c%0d", c), {16'd0, wr_i, wr_j}, {16'd0, ew[c]});
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    hold = 1'b0;
  endtask
  initial begin
    #12;
    check("reset", {15'd0, issue_vld, mac_en, mac_clr, d_we, busy, done, si, sj, sk} & 32'h3f_ffffff,
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(2, 2, 2, 0, 1'b0);
    run(1, 1, 1, 0, 1'b0);
    run(3, 2, 0, 0, 1'b0);
    run(0, 2, 2, 0, 1'b0);
    run(1, 1, 4, 2, 1'b0);
    run(2, 3, 2, 0, 1'b1);
    run(2, 2, 1, 1, 1'b0);
    // abort mid-run with asynchronous reset
    @(negedge clk);
    start = 1'b1;
    ci = 3;
    cj = 3;
    ck = 3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("async rst", {20'd0, issue_vld, mac_en, mac_clr, d_we, busy, done, si == 0, sj == 0, sk == 0, wr_i == 0, wr_j == 0},
             {20'd0, 11'b00000011111});
    @(negedge clk);
    check("rst held", {26'd0, issue_vld, mac_en, mac_clr, d_we, busy, done}, 32'd0);
    rst_n = 1'b1;
    run(2, 1, 3, 0, 1'b0);
    for (int t = 0; t < 25; t++)
      run($urandom_range(1, 4), $urandom_range(1, 4), ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4),
          $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
